xbus_slave_responder_bfm: RTL
=============================

# xbus_slave_responder_bfm

Synthesizable XBus slave responder that sits directly upstream of the slave monitor BFM on the slave side of the bus. It decodes XBus address phases within its address window, drives `sig_wait` wait states and read data, and stores write data in an internal byte memory. It generates exactly the `sig_wait`/`sig_data` activity the slave monitor samples.

## Interface
Parameters:
- `BASE_ADDR`, 16'h0000: first byte address of the window.
- `MEM_DEPTH`, 256: window size in bytes; power of two, 16 to 4096. `BASE_ADDR` is aligned to `MEM_DEPTH`.
- `WAIT_CYCLES`, 0: wait states inserted before every data beat; 0 to 15.

Ports:
- `sig_clock` in 1: bus clock. All sampling and updates happen on the rising edge.
- `sig_reset_n` in 1: reset, asynchronous, active-low.
- `sig_addr` in 16: transfer start address, valid in the address phase.
- `sig_size` in 2: beats per transfer, N = 1/2/4/8 for 00/01/10/11.
- `sig_read` in 1: read request, address phase.
- `sig_write` in 1: write request, address phase.
- `sig_data_in` in 8: write data from master.
- `sig_wait` out 1: wait-state indication, registered.
- `sig_data_out` out 8: read data, registered.
- `sig_data_oe` out 1: drive-enable for `sig_data_out` onto the bus, registered.
- `sig_error` out 1: transfer error, registered. Tied 0 unless the macro is enabled.

## Operation
- FSM states are IDLE, WAIT, XFER.
- **IDLE:** samples the address phase. It accepts a transfer when all of these hold:
  - exactly one of `sig_read`/`sig_write` is 1;
  - `sig_addr` is in [BASE_ADDR, BASE_ADDR+MEM_DEPTH-1].
- **Capture:** on accept, the block latches:
  - `offset = sig_addr - BASE_ADDR`;
  - N;
  - direction;
  - beat counter = 0.
- **Next state after capture:**
  - WAIT with a wait counter of `WAIT_CYCLES` if `WAIT_CYCLES > 0`;
  - XFER otherwise.
- **Ignored address phases:**
  - `sig_read && sig_write` is a protocol violation and is ignored.
  - An out-of-window address is ignored; another slave owns it.
  - The block stays IDLE in both cases.
- **WAIT:** `sig_wait` = 1. The counter decrements each cycle. At the edge where the counter reaches 1, the FSM moves to XFER.
- **XFER:** exactly one cycle per beat with `sig_wait` = 0.
  - Beat k addresses memory index `(offset + k) mod MEM_DEPTH`.
  - Byte lane order is beat 0 = lowest address.
- **Read beat:** `sig_data_out` = mem[index] and `sig_data_oe` = 1 for that cycle.
- **Write beat:** at the end of the XFER cycle, the block writes `sig_data_in` into mem[index]. `sig_data_oe` stays 0.
- **After each XFER:**
  - if k < N-1: k increments, then the FSM goes to WAIT (if `WAIT_CYCLES` > 0) or back to XFER;
  - if k = N-1: the FSM goes to IDLE.
- Address-phase inputs are ignored outside IDLE.
- Memory is not reset; its contents are undefined until written.

## Timing
- Reset values: `sig_wait`=0, `sig_data_out`=8'h00, `sig_data_oe`=0, `sig_error`=0, FSM=IDLE, counters=0.
- **Reset mid-transfer:** all outputs return to their reset values immediately (asynchronously). The transfer is abandoned and memory keeps its contents.
- **Address phase:** cycle A. The data phase starts in cycle A+1.
- **First data cycle:**
  - `sig_wait` is already 1 in cycle A+1 when `WAIT_CYCLES` > 0; it is registered at the capture edge.
  - When `WAIT_CYCLES` = 0, `sig_wait` stays 0 and beat 0 transfers in cycle A+1.
- **Data phase length:** N*(WAIT_CYCLES+1) cycles. Read data is valid in exactly the cycles where `sig_wait`=0 and `sig_data_oe`=1.
- **Back-to-back:** the cycle after the last XFER is IDLE and may itself be a new accepted address phase.
- Outside an accepted transfer, `sig_wait`, `sig_data_oe` and `sig_error` are 0 and `sig_data_out` is 8'h00.

## Configuration
- Macro: `XBUS_SLAVE_RESP_ERROR_EN`.
- **Defined:** a transfer whose last beat would cross the window end (offset + N > MEM_DEPTH) raises an error.
  - `sig_error` = 1 in each XFER cycle of that transfer.
  - Writes are dropped.
  - Reads return 8'h00 with `sig_data_oe`=1.
  - Wait states are unchanged.
- **Undefined:** such a transfer wraps modulo MEM_DEPTH and `sig_error` is constant 0.

## Test plan
- **Single-byte write then read, WAIT_CYCLES=0:** write 8'hA5 to 16'h0010 (size 00), then read 16'h0010 → read data 8'hA5 in cycle A+1, `sig_wait` never 1.
- **Eight-byte write then read, WAIT_CYCLES=2:** write 8'h11..8'h88 to 16'h0020 (size 11), then read 16'h0020 → each beat is preceded by 2 cycles of `sig_wait`=1; data phase is 24 cycles; read beats return 8'h11..8'h88 in order.
- **Out-of-window and illegal address phases:** read at BASE_ADDR+MEM_DEPTH, and an address phase with `sig_read`=`sig_write`=1 → no response, all outputs stay 0, FSM stays IDLE.
- **Window crossing, MEM_DEPTH=256:** four-byte write at offset 8'hFE.
  - Macro undefined → bytes land at 8'hFE, 8'hFF, 8'h00, 8'h01.
  - Macro defined → `sig_error`=1 on all 4 XFER cycles and memory is unchanged.
- **Reset mid-transfer:** assert `sig_reset_n`=0 during beat 2 of an 8-byte read → outputs reset immediately; after release, an address phase is accepted in the first cycle and bytes written before the reset read back intact.
- **Back-to-back:** a 2-byte read immediately followed by a 1-byte write in the next cycle → both are accepted with no idle gap and data is correct.

Source files
------------

// File: rtl/xbus_slave_responder_bfm.sv
`default_nettype none
// ============================================================================
// Module   : xbus_slave_responder_bfm
// Brief    : XBus slave responder with an internal byte memory and
//            programmable wait states; optional window-crossing error
//            reporting enabled by XBUS_SLAVE_RESP_ERROR_EN.
// Revision : 1.0
// ============================================================================
module xbus_slave_responder_bfm #(
    parameter logic [15:0] BASE_ADDR   = 16'h0000,
    parameter int          MEM_DEPTH   = 256,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic        sig_clock,
    input  logic        sig_reset_n,
    input  logic [15:0] sig_addr,
    input  logic [1:0]  sig_size,
    input  logic        sig_read,
    input  logic        sig_write,
    input  logic [7:0]  sig_data_in,
    output logic        sig_wait,
    output logic [7:0]  sig_data_out,
    output logic        sig_data_oe,
    output logic        sig_error
);

    localparam int         AW          = $clog2(MEM_DEPTH);
    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_WAIT      = 2'd1;
    localparam logic [1:0] c_XFER      = 2'd2;
    localparam logic [3:0] c_WAIT_LOAD = 4'(WAIT_CYCLES);
    localparam bit         c_HAS_WAIT  = (WAIT_CYCLES > 0);

    logic [7:0]    r_mem [MEM_DEPTH];

    logic [1:0]    r_state;
    logic [2:0]    r_beat;
    logic [2:0]    r_last;
    logic [AW-1:0] r_idx;
    logic          r_is_read;
    logic          r_err;
    logic [3:0]    r_wait_cnt;

    logic          r_wait;
    logic [7:0]    r_data_out;
    logic          r_data_oe;

    logic [1:0]    w_next_state;
    logic          w_in_window;
    logic          w_accept;
    logic [AW-1:0] w_addr_off;
    logic [2:0]    w_size_last;
    logic          w_cap_err;
    logic [AW-1:0] w_next_idx;
    logic          w_next_read;
    logic          w_next_err;
    logic          w_nxt_wait;
    logic          w_nxt_oe;
    logic [7:0]    w_nxt_data;
    logic          w_mem_we;

    // Window is aligned to its size, so an upper-bit match is a full range check.
    assign w_in_window = (sig_addr[15:AW] == BASE_ADDR[15:AW]);
    assign w_accept    = (sig_read ^ sig_write) && w_in_window;
    assign w_addr_off  = sig_addr[AW-1:0];

    always_comb begin
        w_size_last = 3'd0;
        case (sig_size)
            2'b00:   w_size_last = 3'd0;
            2'b01:   w_size_last = 3'd1;
            2'b10:   w_size_last = 3'd3;
            default: w_size_last = 3'd7;
        endcase
    end

`ifdef XBUS_SLAVE_RESP_ERROR_EN
    logic [AW:0] w_end;
    logic        w_nxt_error;
    logic        r_error;

    // Carry out of offset + (N-1) means the last beat lies past the window end.
    assign w_end     = {1'b0, w_addr_off} + (AW+1)'(w_size_last);
    assign w_cap_err = w_end[AW];
`else
    assign w_cap_err = 1'b0;
`endif

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_next_state = c_HAS_WAIT ? c_WAIT : c_XFER;
                end
            end
            c_WAIT: begin
                if (r_wait_cnt <= 4'd1) begin
                    w_next_state = c_XFER;
                end
            end
            c_XFER: begin
                if (r_beat == r_last) begin
                    w_next_state = c_IDLE;
                end else begin
                    w_next_state = c_HAS_WAIT ? c_WAIT : c_XFER;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    // Output logic: outputs are registered, so they are computed for the next cycle.
    always_comb begin
        w_next_idx  = r_idx;
        w_next_read = r_is_read;
        w_next_err  = r_err;
        case (r_state)
            c_IDLE: begin
                w_next_idx  = w_addr_off;
                w_next_read = sig_read;
                w_next_err  = w_cap_err;
            end
            c_XFER: begin
                w_next_idx  = r_idx + AW'(1);
            end
            default: ;
        endcase
        w_nxt_wait = (w_next_state == c_WAIT);
        w_nxt_oe   = (w_next_state == c_XFER) && w_next_read;
        w_nxt_data = (w_nxt_oe && !w_next_err) ? r_mem[w_next_idx] : 8'h00;
    end

    assign w_mem_we = (r_state == c_XFER) && !r_is_read && !r_err;

    // State register and transfer bookkeeping
    always_ff @(posedge sig_clock or negedge sig_reset_n) begin
        if (!sig_reset_n) begin
            r_state    <= c_IDLE;
            r_beat     <= 3'd0;
            r_last     <= 3'd0;
            r_idx      <= '0;
            r_is_read  <= 1'b0;
            r_err      <= 1'b0;
            r_wait_cnt <= 4'd0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_beat     <= 3'd0;
                        r_last     <= w_size_last;
                        r_idx      <= w_addr_off;
                        r_is_read  <= sig_read;
                        r_err      <= w_cap_err;
                        r_wait_cnt <= c_WAIT_LOAD;
                    end
                end
                c_WAIT: begin
                    r_wait_cnt <= r_wait_cnt - 4'd1;
                end
                c_XFER: begin
                    if (r_beat != r_last) begin
                        r_beat     <= r_beat + 3'd1;
                        r_idx      <= r_idx + AW'(1);
                        r_wait_cnt <= c_WAIT_LOAD;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sig_clock or negedge sig_reset_n) begin
        if (!sig_reset_n) begin
            r_wait     <= 1'b0;
            r_data_out <= 8'h00;
            r_data_oe  <= 1'b0;
        end else begin
            r_wait     <= w_nxt_wait;
            r_data_out <= w_nxt_data;
            r_data_oe  <= w_nxt_oe;
        end
    end

    // Memory has no reset so its contents survive a mid-transfer reset.
    always_ff @(posedge sig_clock) begin
        if (w_mem_we) begin
            r_mem[r_idx] <= sig_data_in;
        end
    end

`ifdef XBUS_SLAVE_RESP_ERROR_EN
    assign w_nxt_error = (w_next_state == c_XFER) && w_next_err;

    always_ff @(posedge sig_clock or negedge sig_reset_n) begin
        if (!sig_reset_n) begin
            r_error <= 1'b0;
        end else begin
            r_error <= w_nxt_error;
        end
    end

    assign sig_error = r_error;
`else
    assign sig_error = 1'b0;
`endif

    assign sig_wait     = r_wait;
    assign sig_data_out = r_data_out;
    assign sig_data_oe  = r_data_oe;

endmodule
`default_nettype wire
